// File: rtl/gray_bcd_display.sv
// Gray-coded switch word -> synchronise, debounce, Gray-to-binary, double-dabble BCD -> 7-segment digits.
// Optional feature macro: GRAY_BCD_BLANK_LEADING_EN (blank leading zero digits above digit 0).
module gray_bcd_display #(
  parameter int WIDTH           = 8,
  parameter int DIGITS          = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACT_THRESHOLD   = 128
) (
  input  logic                  clock50,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      gray_in,
  output logic [7*DIGITS-1:0]   seg,
  output logic [WIDTH-1:0]      led,
  output logic [WIDTH-1:0]      value_bin,
  output logic                  actuator,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_CYCLES);
  localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH - 1);
  localparam logic [31:0]   THRESH    = 32'(ACT_THRESHOLD);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_LOAD} state_t;
  state_t r_state, w_state_next;

  logic [WIDTH-1:0]    r_sync1, r_sync2, r_cand, r_last, r_bin;
  logic [CW-1:0]       r_db_cnt;
  logic                r_first;
  logic [SW-1:0]       r_shreg, w_shreg_adj;
  logic [IW-1:0]       r_iter;
  logic [WIDTH-1:0]    w_cand_bin;
  logic                w_accept;
  logic [7*DIGITS-1:0] w_seg, r_seg;
  logic [DIGITS-1:0]   w_blank;
  logic [WIDTH-1:0]    r_value;
  logic                r_act, r_done;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Debounce keeps running regardless of FSM state so a word settling mid-conversion is ready at IDLE.
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= gray_in;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand   <= r_sync2;
        r_db_cnt <= '0;
      end else if (r_db_cnt != DB_MAX) begin
        r_db_cnt <= r_db_cnt + CW'(1);
      end
    end
  end

  // Binary bit i is the XOR of all Gray bits at or above i.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray2bin
    assign w_cand_bin[gi] = ^r_cand[WIDTH-1:gi];
  end

  assign w_accept = (r_db_cnt == DB_MAX) && (r_state == S_IDLE) &&
                    ((r_cand != r_last) || r_first);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] w_nib;
    assign w_nib = r_shreg[WIDTH+4*gi +: 4];
    assign w_shreg_adj[WIDTH+4*gi +: 4] = (w_nib >= 4'd5) ? w_nib + 4'd3 : w_nib;
`ifdef GRAY_BCD_BLANK_LEADING_EN
    assign w_blank[gi] = (gi != 0) && !(|r_shreg[SW-1:WIDTH+4*gi]);
`else
    assign w_blank[gi] = 1'b0;
`endif
    assign w_seg[7*gi +: 7] = w_blank[gi] ? 7'h00 : seg7(w_nib);
  end
  assign w_shreg_adj[WIDTH-1:0] = r_shreg[WIDTH-1:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = S_CONVERT;
      S_CONVERT: if (r_iter == ITER_LAST) w_state_next = S_LOAD;
      S_LOAD:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_iter  <= '0;
      r_bin   <= '0;
      r_last  <= '0;
      r_first <= 1'b1;
      r_seg   <= '0;
      r_value <= '0;
      r_act   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shreg <= {{BW{1'b0}}, w_cand_bin};
            r_bin   <= w_cand_bin;
            r_last  <= r_cand;
            r_first <= 1'b0;
            r_iter  <= '0;
          end
        end
        S_CONVERT: begin
          r_shreg <= w_shreg_adj << 1;
          r_iter  <= r_iter + IW'(1);
        end
        S_LOAD: begin
          r_seg   <= w_seg;
          r_value <= r_bin;
          r_act   <= (32'(r_bin) >= THRESH);
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign seg       = r_seg;
  assign led       = r_sync2;
  assign value_bin = r_value;
  assign actuator  = r_act;
  assign busy      = (r_state == S_CONVERT) || (r_state == S_LOAD);
  assign done      = r_done;
endmodule

// File: tb/tb_gray_bcd_display.sv
// Directed bench for gray_bcd_display (WIDTH=8, DIGITS=3, DEBOUNCE_CYCLES=4, ACT_THRESHOLD=128).
module tb_gray_bcd_display;
  localparam int W   = 8;
  localparam int DG  = 3;
  localparam int DB  = 4;
  // Edges counted from the first edge that samples the new word up to the edge raising done.
  localparam int LAT = DB + W + 5;

  localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
  localparam logic [6:0] S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07, S8 = 7'h7F, S9 = 7'h6F;
`ifdef GRAY_BCD_BLANK_LEADING_EN
  localparam logic [6:0] Z = 7'h00;
`else
  localparam logic [6:0] Z = S0;
`endif

  logic            clock50, reset_n;
  logic [W-1:0]    gray_in;
  logic [7*DG-1:0] seg;
  logic [W-1:0]    led, value_bin;
  logic            actuator, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  gray_bcd_display #(
    .WIDTH(W), .DIGITS(DG), .DEBOUNCE_CYCLES(DB), .ACT_THRESHOLD(128)
  ) dut (
    .clock50(clock50), .reset_n(reset_n), .gray_in(gray_in), .seg(seg), .led(led),
    .value_bin(value_bin), .actuator(actuator), .busy(busy), .done(done)
  );

  initial clock50 = 1'b0;
  always #5 clock50 = ~clock50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every displayed digit must be a decimal pattern (or blank when leading-zero blanking is on).
  always @(negedge clock50) begin
    if (reset_n && done) begin
      for (int d = 0; d < DG; d++) begin
        logic [6:0] f;
        logic ok;
        f  = seg[7*d +: 7];
        ok = (f == S0) || (f == S1) || (f == S2) || (f == S3) || (f == S4) ||
             (f == S5) || (f == S6) || (f == S7) || (f == S8) || (f == S9) || (f == Z);
        check_eq("seg_valid", 32'(ok), 32'd1);
      end
    end
  end

  task automatic wait_done(input string tag, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(posedge clock50); #1;
      cyc++;
    end while (!done && cyc < limit);
    check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic wait_busy(input string tag, input int limit);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clock50); #1;
      cyc++;
    end while (!busy && cyc < limit);
    check_eq({tag, "_busy_seen"}, 32'(busy), 32'd1);
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] eb, input logic [7*DG-1:0] es,
                           input logic ea);
    check_eq({tag, "_bin"}, 32'(value_bin), 32'(eb));
    check_eq({tag, "_seg"}, 32'(seg), 32'(es));
    check_eq({tag, "_act"}, 32'(actuator), 32'(ea));
    $display("txn %s: value_bin=%0d seg=%h actuator=%0b", tag, value_bin, seg, actuator);
  endtask

  // Called just after a rising edge; checks latency, LOAD-cycle busy, outputs and done width.
  task automatic run_vec(input string tag, input logic [W-1:0] g, input logic [W-1:0] eb,
                         input logic [7*DG-1:0] es, input logic ea);
    int k;
    gray_in = g;
    k = 0;
    while (k < 60) begin
      @(posedge clock50); #1;
      k++;
      if (k == LAT - 1) check_eq({tag, "_busy_load"}, 32'(busy), 32'd1);
      if (done) break;
    end
    check_eq({tag, "_latency"}, 32'(k), 32'(LAT));
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_out(tag, eb, es, ea);
    @(posedge clock50); #1;
    check_eq({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int k, n_done;
    reset_n = 1'b0;
    gray_in = '0;
    repeat (3) @(posedge clock50);
    #1;
    check_eq("rst_seg", 32'(seg), 32'd0);
    check_eq("rst_led", 32'(led), 32'd0);
    check_eq("rst_bin", 32'(value_bin), 32'd0);
    check_eq("rst_act", 32'(actuator), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    wait_done("boot", 60, k);
    check_out("boot", 8'd0, {Z, Z, S0}, 1'b0);

    // Three-cycle glitch must not reach the display, but led mirrors it.
    gray_in = 8'hFF;
    repeat (2) @(posedge clock50);
    #1;
    check_eq("glitch_led_hi", 32'(led), 32'hFF);
    @(posedge clock50); #1;
    gray_in = 8'h00;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock50); #1;
      if (done) n_done++;
    end
    check_eq("glitch_no_done", 32'(n_done), 32'd0);
    check_eq("glitch_seg", 32'(seg), 32'({Z, Z, S0}));
    check_eq("glitch_led_lo", 32'(led), 32'h00);
    $display("txn glitch: done_pulses=%0d seg=%h", n_done, seg);

    run_vec("g80", 8'h80, 8'd255, {S2, S5, S5}, 1'b1);
    run_vec("g0D", 8'h0D, 8'd9,   {Z, Z, S9},   1'b0);
    run_vec("gC0", 8'hC0, 8'd128, {S1, S2, S8}, 1'b1);
    run_vec("g40", 8'h40, 8'd127, {S1, S2, S7}, 1'b0);
    run_vec("g1F", 8'h1F, 8'd21,  {Z, S2, S1},  1'b0);

    // Second word arrives mid-conversion; expect 1 then 2, spaced by the minimum W+2.
    gray_in = 8'h01;
    wait_busy("b2b", 30);
    gray_in = 8'h03;
    wait_done("b2b_first", 40, k);
    check_out("b2b_first", 8'd1, {Z, Z, S1}, 1'b0);
    wait_done("b2b_second", 40, k);
    check_eq("b2b_spacing", 32'(k), 32'(W + 2));
    check_out("b2b_second", 8'd2, {Z, Z, S2}, 1'b0);
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock50); #1;
      if (done) n_done++;
    end
    check_eq("b2b_no_extra", 32'(n_done), 32'd0);

    // Asynchronous reset during CONVERT clears outputs at once; the held input reconverts after.
    gray_in = 8'h80;
    wait_busy("midrst", 30);
    repeat (3) @(posedge clock50);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_seg", 32'(seg), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_bin", 32'(value_bin), 32'd0);
    check_eq("midrst_act", 32'(actuator), 32'd0);
    @(posedge clock50); #1;
    reset_n = 1'b1;
    wait_done("midrst_reconv", 60, k);
    check_out("midrst_reconv", 8'd255, {S2, S5, S5}, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
